seg7_scan_driver: RTL and testbench

//  Consumes the 32-bit display word produced by the channel-select display mux (seg7_data) and drives the

---
 rtl/seg7_scan_driver.sv | 134 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an 8-digit common-anode
// 7-segment display. One nibble per digit is hex-decoded, with per-digit
// decimal point and blanking. Incoming words are double-buffered and
// committed only at a frame boundary, so a frame never mixes two words.
module seg7_scan_driver #(
   parameter int unsigned DIV_CNT = 100000,
   parameter int unsigned CNT_W   = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] data_in,
   input  logic [7:0]  point_in,
   input  logic [7:0]  blank_in,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_cat,
   output logic        pending,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CNT - 1);

   // prescaler and digit scan index
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;

   // word currently on display
   logic [31:0]      act_data;
   logic [7:0]       act_point;
   logic [7:0]       act_blank;

   // word waiting for the next frame boundary
   logic [31:0]      pend_data;
   logic [7:0]       pend_point;
   logic [7:0]       pend_blank;

   logic             tick;
   logic             boundary;
   logic [3:0]       cur_nib;
   logic [7:0]       an_next;
   logic [7:0]       cat_next;

   // hex digit to segments {g,f,e,d,c,b,a}, active low
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // digit-advance tick, frame boundary and next pin values for the current digit
   always_comb begin
      tick     = (cnt == CNT_LAST);
      boundary = tick && (idx == 3'd7);
      cur_nib  = act_data[{idx, 2'b00} +: 4];
      an_next  = act_blank[idx] ? 8'hFF : ~(8'h01 << idx);
      cat_next = {~act_point[idx], hex7(cur_nib)};
   end

   // prescaler counts 0..DIV_CNT-1; each wrap advances the lit digit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (tick) begin
         cnt <= '0;
         idx <= idx + 3'd1;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // double buffer: load fills the pending word, the frame boundary commits it;
   // a load landing on the boundary itself bypasses straight to the active word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         act_data   <= '0;
         act_point  <= '0;
         act_blank  <= '1;
         pend_data  <= '0;
         pend_point <= '0;
         pend_blank <= '0;
         pending    <= 1'b0;
      end else if (load && boundary) begin
         act_data   <= data_in;
         act_point  <= point_in;
         act_blank  <= blank_in;
         pending    <= 1'b0;
      end else begin
         if (boundary && pending) begin
            act_data  <= pend_data;
            act_point <= pend_point;
            act_blank <= pend_blank;
            pending   <= 1'b0;
         end
         if (load) begin
            pend_data  <= data_in;
            pend_point <= point_in;
            pend_blank <= blank_in;
            pending    <= 1'b1;
         end
      end
   end

   // registered pin drive and frame-wrap pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_an     <= '1;
         seg_cat    <= '1;
         frame_done <= 1'b0;
      end else begin
         seg_an     <= an_next;
         seg_cat    <= cat_next;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scenarios plus a randomized load phase,
// each cycle compared against a cycle-count based reference model.
module tb_seg7_scan_driver;

   localparam int unsigned DIV   = 4;
   localparam int unsigned FRAME = 8 * DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [31:0] data_in = '0;
   logic [7:0]  point_in = '0;
   logic [7:0]  blank_in = '0;
   logic [7:0]  seg_an;
   logic [7:0]  seg_cat;
   logic        pending;
   logic        frame_done;

   seg7_scan_driver #(.DIV_CNT(DIV), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
      .point_in(point_in), .blank_in(blank_in), .seg_an(seg_an),
      .seg_cat(seg_cat), .pending(pending), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model: t counts clock edges since reset release
   int unsigned t = 0;
   logic [31:0] m_data = '0, p_data = '0;
   logic [7:0]  m_point = '0, m_blank = '1, p_point = '0, p_blank = '0;
   logic        m_pend = 1'b0;
   logic [7:0]  e_an = '1, e_cat = '1;
   logic        e_fd = 1'b0;
   logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   // one clock: advance the model on the edge, then compare all outputs
   task automatic cyc();
      int unsigned d;
      logic bnd;
      @(posedge clk);
      if (!rst_n) begin
         t = 0;
         m_data = '0; m_point = '0; m_blank = '1;
         p_data = '0; p_point = '0; p_blank = '0;
         m_pend = 1'b0;
         e_an = '1; e_cat = '1; e_fd = 1'b0;
      end else begin
         d = (t / DIV) % 8;
         e_an  = m_blank[d] ? 8'hFF : ~(8'h01 << d);
         e_cat = {~m_point[d], hex_tab[m_data[4*d +: 4]]};
         bnd   = (t % FRAME) == FRAME - 1;
         e_fd  = bnd;
         if (load && bnd) begin
            m_data = data_in; m_point = point_in; m_blank = blank_in;
            m_pend = 1'b0;
         end else begin
            if (bnd && m_pend) begin
               m_data = p_data; m_point = p_point; m_blank = p_blank;
               m_pend = 1'b0;
            end
            if (load) begin
               p_data = data_in; p_point = point_in; p_blank = blank_in;
               m_pend = 1'b1;
            end
         end
         t++;
      end
      #1;
      chk8("seg_an", seg_an, e_an);
      chk8("seg_cat", seg_cat, e_cat);
      chk8("pending", {7'b0, pending}, {7'b0, m_pend});
      chk8("frame_done", {7'b0, frame_done}, {7'b0, e_fd});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
      load = 1'b1; data_in = d; point_in = p; blank_in = b;
      cyc();
      load = 1'b0;
   endtask

   // run until the DUT reports a frame wrap, bounded to two frames
   task automatic wait_boundary(input string tag);
      int n;
      n = 0;
      do begin
         cyc();
         n++;
      end while (frame_done !== 1'b1 && n < 2 * FRAME);
      chk8(tag, {7'b0, frame_done}, 8'h01);
   endtask

   // run until the next edge is the model's frame boundary
   task automatic align_to_boundary();
      for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) cyc();
   endtask

   int fd_cnt;

   initial begin
      // 1: reset held three cycles, then a dark first frame
      rst_n = 1'b0;
      run(3);
      chk8("rst_an", seg_an, 8'hFF);
      chk8("rst_cat", seg_cat, 8'hFF);
      rst_n = 1'b1;
      run(20);
      chk8("dark_an", seg_an, 8'hFF);
      run(22);

      // 2: mid-frame load, committed at the boundary
      pulse_load(32'hAA5555AA, 8'h00, 8'h00);
      chk8("t2_pend_set", {7'b0, pending}, 8'h01);
      wait_boundary("t2_wait");
      chk8("t2_pend_clr", {7'b0, pending}, 8'h00);
      cyc();
      chk8("t2_d0_an", seg_an, 8'hFE);
      chk8("t2_d0_cat", seg_cat, 8'h88);
      run(4);
      chk8("t2_d1_an", seg_an, 8'hFD);
      chk8("t2_d1_cat", seg_cat, 8'h88);
      run(4);
      chk8("t2_d2_an", seg_an, 8'hFB);
      chk8("t2_d2_cat", seg_cat, 8'h92);
      fd_cnt = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         cyc();
         if (frame_done === 1'b1) fd_cnt++;
      end
      chk8("t2_fd_rate", 8'(fd_cnt), 8'd2);

      // 3: two loads in one frame, last one wins
      run(3);
      pulse_load(32'h12345678, 8'h00, 8'h00);
      run(2);
      pulse_load(32'h9ABCDEF0, 8'h00, 8'h00);
      wait_boundary("t3_wait");
      cyc();
      chk8("t3_d0_cat", seg_cat, 8'hC0);
      run(28);
      chk8("t3_d7_an", seg_an, 8'h7F);
      chk8("t3_d7_cat", seg_cat, 8'h90);

      // 4: load coincident with the boundary goes straight to display
      align_to_boundary();
      pulse_load(32'h00000000, 8'h01, 8'h00);
      chk8("t4_pend", {7'b0, pending}, 8'h00);
      chk8("t4_fd", {7'b0, frame_done}, 8'h01);
      cyc();
      chk8("t4_d0_an", seg_an, 8'hFE);
      chk8("t4_d0_cat", seg_cat, 8'h40);

      // 5: upper four digits blanked
      run(5);
      pulse_load(32'h0F1E2D3C, 8'h5A, 8'hF0);
      wait_boundary("t5_wait");
      cyc();
      chk8("t5_d0_an", seg_an, 8'hFE);
      run(16);
      chk8("t5_d4_an", seg_an, 8'hFF);
      run(12);
      chk8("t5_d7_an", seg_an, 8'hFF);

      // randomized loads of random words, points and blanks
      for (int i = 0; i < 400; i++) begin
         data_in  = $urandom;
         point_in = 8'($urandom);
         blank_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         load     = ($urandom_range(0, 9) == 0);
         cyc();
      end
      load = 1'b0;

      // 6: reset at digit 5 with a word pending
      for (int i = 0; i < FRAME && ((t / DIV) % 8) != 5; i++) cyc();
      pulse_load(32'hDEADBEEF, 8'hFF, 8'h00);
      chk8("t6_pend_set", {7'b0, pending}, 8'h01);
      rst_n = 1'b0;
      cyc();
      chk8("t6_rst_an", seg_an, 8'hFF);
      chk8("t6_rst_cat", seg_cat, 8'hFF);
      chk8("t6_rst_pend", {7'b0, pending}, 8'h00);
      rst_n = 1'b1;
      run(2 * FRAME + 3);
      chk8("t6_dark_an", seg_an, 8'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
